// File: rtl/mem_port_arbiter_if.sv
// Handshake and RAM bus between the IF / EX-MEM requesters,
// the memory port arbiter and the single-port block RAM.
//
// Signals:
//   if_req/if_addr -> if_rdata/if_valid   : instruction fetch port
//   d_req/d_we/d_size/d_addr/d_wdata
//                  -> d_rdata/d_valid     : data load/store port
//   ram_en/ram_we/ram_addr/ram_wdata
//                  <- ram_rdata           : RAM macro port
//   stall                                 : pipeline stall
// Modports:
//   slave  : the arbiter itself
//   master : requesters + RAM (the environment around the arbiter)

interface mem_port_arbiter_if;
    logic        if_req;
    logic [13:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;

    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [13:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;

    logic        ram_en;
    logic [3:0]  ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic        stall;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_valid,
        input  d_req, d_we, d_size, d_addr, d_wdata,
        output d_rdata, d_valid,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata,
        output stall
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_valid,
        output d_req, d_we, d_size, d_addr, d_wdata,
        input  d_rdata, d_valid,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata,
        input  stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port block RAM between instruction
// fetch (IF) and the EX/MEM data requester (D).
//
// Ports:
//   clk   : system clock, all state on posedge
//   rst_n : asynchronous reset, ACTIVE-HIGH despite the name
//   bus   : mem_port_arbiter_if.slave (requesters, RAM, stall)
// Parameters:
//   RAM_LAT   : RAM read latency, ram_en -> ram_rdata (1..4)
//   MAX_D_RUN : D grants in a row while IF waits (1..15)

module mem_port_arbiter #(
    parameter int unsigned RAM_LAT   = 1,
    parameter int unsigned MAX_D_RUN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam logic [2:0] LAT_LOAD = 3'(RAM_LAT);
    localparam logic [3:0] RUN_MAX  = 4'(MAX_D_RUN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } owner_t;

    state_t      r_state;
    state_t      w_state_nxt;
    owner_t      r_owner;
    logic [2:0]  r_lat;
    logic [3:0]  r_run;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;

    logic        w_idle;
    logic        w_gnt_d;
    logic        w_gnt_if;
    logic        w_gnt;
    logic        w_wait_end;
    logic        w_if_valid;
    logic        w_d_valid;
    logic        w_stall;
    logic [3:0]  w_lane_we;
    logic [31:0] w_lane_wd;
    logic        w_ram_en;
    logic [3:0]  w_ram_we;
    logic [11:0] w_ram_addr;
    logic [31:0] w_ram_wdata;
    logic        w_unused;

    // Fetch addresses are word-aligned by construction.
    assign w_unused = &{1'b0, bus.if_addr[1:0]};

    // Grants are combinational from IDLE so ram_en lands in the
    // same cycle the decision is made. Reset gates them so the
    // RAM sees nothing while reset is held.
    always_comb begin
        w_idle   = (r_state == S_IDLE) && !rst_n;
        w_gnt_d  = w_idle && bus.d_req
                   && !(bus.if_req && (r_run == RUN_MAX));
        w_gnt_if = w_idle && bus.if_req && !w_gnt_d;
        w_gnt    = w_gnt_d || w_gnt_if;
        w_wait_end = (r_state == S_WAIT)
                     && (r_lat == 3'd1);
    end

    // Byte-lane enables and replicated store data by size.
    always_comb begin
        w_lane_we = 4'b1111;
        w_lane_wd = bus.d_wdata;
        case (bus.d_size)
            2'b00: begin
                w_lane_we = 4'b0001 << bus.d_addr[1:0];
                w_lane_wd = {4{bus.d_wdata[7:0]}};
            end
            2'b01: begin
                w_lane_we = bus.d_addr[1] ? 4'b1100
                                          : 4'b0011;
                w_lane_wd = {2{bus.d_wdata[15:0]}};
            end
            default: begin
                w_lane_we = 4'b1111;
                w_lane_wd = bus.d_wdata;
            end
        endcase
    end

    // RAM strobes exist only in the grant cycle.
    always_comb begin
        w_ram_en    = w_gnt;
        w_ram_we    = '0;
        w_ram_addr  = '0;
        w_ram_wdata = '0;
        if (w_gnt_d) begin
            w_ram_addr = bus.d_addr[13:2];
            if (bus.d_we) begin
                w_ram_we    = w_lane_we;
                w_ram_wdata = w_lane_wd;
            end
        end else if (w_gnt_if) begin
            w_ram_addr = bus.if_addr[13:2];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_gnt) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_wait_end) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_if_valid = (r_state == S_DONE)
                     && (r_owner == OWN_IF);
        w_d_valid  = (r_state == S_DONE)
                     && (r_owner == OWN_D);
        w_stall    = !rst_n
                     && ((bus.if_req && !w_if_valid)
                      || (bus.d_req && !w_d_valid));
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state    <= S_IDLE;
            r_owner    <= OWN_NONE;
            r_lat      <= '0;
            r_run      <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_gnt) begin
                r_owner <= w_gnt_d ? OWN_D : OWN_IF;
                r_lat   <= LAT_LOAD;
            end else if (r_state == S_WAIT) begin
                r_lat <= r_lat - 3'd1;
            end else if (r_state == S_DONE) begin
                r_owner <= OWN_NONE;
            end

            // Counts D grants that made a waiting IF wait.
            if (w_gnt_if) begin
                r_run <= '0;
            end else if (w_gnt_d) begin
                if (!bus.if_req) begin
                    r_run <= '0;
                end else if (r_run != RUN_MAX) begin
                    r_run <= r_run + 4'd1;
                end
            end

            // Capture on the edge into DONE so the data is
            // already registered while the valid pulse is up.
            if (w_wait_end) begin
                if (r_owner == OWN_IF) begin
                    r_if_rdata <= bus.ram_rdata;
                end
                if (r_owner == OWN_D) begin
                    r_d_rdata <= bus.ram_rdata;
                end
            end
        end
    end

    assign bus.if_rdata  = r_if_rdata;
    assign bus.if_valid  = w_if_valid;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.d_valid   = w_d_valid;
    assign bus.ram_en    = w_ram_en;
    assign bus.ram_we    = w_ram_we;
    assign bus.ram_addr  = w_ram_addr;
    assign bus.ram_wdata = w_ram_wdata;
    assign bus.stall     = w_stall;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed steps plus
// randomized single accesses against a byte-level memory model.

module tb_mem_port_arbiter;

    localparam int LAT  = 3;
    localparam int MAXR = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int checks   = 0;
    int failures = 0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .RAM_LAT  (LAT),
        .MAX_D_RUN(MAXR)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // ---------------- RAM macro model ----------------
    logic [31:0] ram_arr [0:4095];
    logic [31:0] pipe    [0:3];
    bit          ram_ready;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'hA5C30F1E;
    endfunction

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 4096; i++) ram_arr[i] = init_word(i);
            ram_ready = 1'b1;
        end
        if (bus.ram_en) begin
            if (bus.ram_we != 4'b0000) begin
                for (int k = 0; k < 4; k++)
                    if (bus.ram_we[k])
                        ram_arr[bus.ram_addr][8*k +: 8] = bus.ram_wdata[8*k +: 8];
            end else begin
                pipe[0] <= ram_arr[bus.ram_addr];
            end
        end
        for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end

    assign bus.ram_rdata = pipe[LAT-1];

    // ---------------- reference memory (bytes) ----------------
    logic [7:0] ref_mem [0:16383];

    function automatic logic [31:0] ref_word(input logic [13:0] a);
        int b;
        b = int'({a[13:2], 2'b00});
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ram_en"},    32'(bus.ram_en), 32'd0);
        chk({tag, "_ram_we"},    32'(bus.ram_we), 32'd0);
        chk({tag, "_ram_addr"},  32'(bus.ram_addr), 32'd0);
        chk({tag, "_ram_wdata"}, bus.ram_wdata, 32'd0);
        chk({tag, "_if_valid"},  32'(bus.if_valid), 32'd0);
        chk({tag, "_d_valid"},   32'(bus.d_valid), 32'd0);
        chk({tag, "_if_rdata"},  bus.if_rdata, 32'd0);
        chk({tag, "_d_rdata"},   bus.d_rdata, 32'd0);
        chk({tag, "_stall"},     32'(bus.stall), 32'd0);
    endtask

    // One complete access from one requester; called at posedge+1.
    task automatic acc(input bit isd, input logic we,
                       input logic [1:0] sz, input logic [13:0] a,
                       input logic [31:0] wd, output int gwait,
                       output logic [3:0] g_we, output logic [11:0] g_addr,
                       output logic [31:0] g_wd);
        int n, cnt, base, extra;
        bit got;
        logic [3:0] exp_we;
        logic [31:0] exp_rd;
        logic vld, ovld;
        exp_rd = ref_word(a);
        if (isd) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_size = sz;
            bus.d_addr = a; bus.d_wdata = wd;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = a;
        end
        got = 1'b0; n = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            if (bus.ram_en) got = 1'b1;
            else begin n++; @(posedge clk); #1; end
        end
        gwait  = n;
        g_we   = bus.ram_we;
        g_addr = bus.ram_addr;
        g_wd   = bus.ram_wdata;
        chk("grant_seen", 32'(got), 32'd1);
        chk("grant_addr", 32'(g_addr), 32'(a[13:2]));
        chk("grant_stall", 32'(bus.stall), 32'd1);
        exp_we = 4'b0000;
        if (isd && we) begin
            cnt  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
            base = int'(a) & ~(cnt - 1);
            for (int k = 0; k < cnt; k++) begin
                exp_we[(base + k) % 4] = 1'b1;
                chk("lane_data", 32'(g_wd[8*((base + k) % 4) +: 8]),
                    32'(wd[8*k +: 8]));
                ref_mem[base + k] = wd[8*k +: 8];
            end
        end
        chk("grant_we", 32'(g_we), 32'(exp_we));
        got = 1'b0; n = 0; extra = 0; vld = 1'b0; ovld = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
            if (bus.ram_en) extra++;
            vld  = isd ? bus.d_valid : bus.if_valid;
            ovld = isd ? bus.if_valid : bus.d_valid;
            if (vld) got = 1'b1;
        end
        chk("valid_latency", 32'(n), 32'(LAT + 1));
        chk("no_extra_en", 32'(extra), 32'd0);
        chk("other_valid", 32'(ovld), 32'd0);
        chk("valid_stall", 32'(bus.stall), 32'd0);
        if (!(isd && we))
            chk("rdata", isd ? bus.d_rdata : bus.if_rdata, exp_rd);
        @(posedge clk); #1;
        if (isd) bus.d_req = 1'b0;
        else     bus.if_req = 1'b0;
    endtask

    initial begin
        int gw, n, ng, c, dv, gc, nbad, gap;
        bit got, isd, exp_if;
        logic [3:0]  gwe;
        logic [11:0] ga;
        logic [31:0] gwd, w;
        logic [1:0]  sz;
        logic        we;
        logic [13:0] a;

        for (int i = 0; i < 4096; i++) begin
            w = init_word(i);
            for (int k = 0; k < 4; k++) ref_mem[4*i + k] = w[8*k +: 8];
        end

        // Reset held with both requests up: everything stays 0.
        bus.if_req = 1'b1; bus.if_addr = 14'h0010;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = 2'b10;
        bus.d_addr = 14'h0020; bus.d_wdata = 32'h11223344;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        bus.if_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;

        // IF read from IDLE.
        acc(1'b0, 1'b0, 2'b00, 14'h0010, 32'h0, gw, gwe, ga, gwd);
        chk("if_grant_wait", 32'(gw), 32'd0);
        chk("if_addr_0x010", 32'(ga), 32'h004);

        // Stores of each size.
        acc(1'b1, 1'b1, 2'b00, 14'h0023, 32'h000000AB, gw, gwe, ga, gwd);
        chk("byte_we", 32'(gwe), 32'b1000);
        chk("byte_addr", 32'(ga), 32'h008);
        chk("byte_wdata", gwd, 32'hABABABAB);
        acc(1'b1, 1'b1, 2'b01, 14'h0006, 32'h00001234, gw, gwe, ga, gwd);
        chk("half_we", 32'(gwe), 32'b1100);
        chk("half_wdata", gwd, 32'h12341234);
        acc(1'b1, 1'b1, 2'b10, 14'h0007, 32'hDEADBEEF, gw, gwe, ga, gwd);
        chk("word_we", 32'(gwe), 32'b1111);
        chk("word_addr", 32'(ga), 32'h001);
        chk("word_wdata", gwd, 32'hDEADBEEF);
        acc(1'b1, 1'b1, 2'b11, 14'h0009, 32'hCAFEF00D, gw, gwe, ga, gwd);
        chk("size11_we", 32'(gwe), 32'b1111);

        // Read back what was stored.
        acc(1'b1, 1'b0, 2'b10, 14'h0020, 32'h0, gw, gwe, ga, gwd);
        acc(1'b0, 1'b0, 2'b00, 14'h0004, 32'h0, gw, gwe, ga, gwd);
        acc(1'b1, 1'b0, 2'b01, 14'h0006, 32'h0, gw, gwe, ga, gwd);

        // Contention: both held; IF wins after MAXR D grants.
        bus.if_addr = 14'h0100;
        bus.d_we = 1'b0; bus.d_size = 2'b10; bus.d_addr = 14'h0200;
        bus.if_req = 1'b1; bus.d_req = 1'b1;
        ng = 0; n = 0;
        while (ng < 6 && n < 300) begin
            @(negedge clk);
            if (bus.ram_en) begin
                exp_if = ((ng % (MAXR + 1)) == MAXR);
                chk("arb_order", 32'(bus.ram_addr),
                    exp_if ? 32'h040 : 32'h080);
                ng++;
            end
            @(posedge clk); #1;
            n++;
        end
        chk("arb_grants", 32'(ng), 32'd6);
        // Both drop mid-access; the IF access still completes.
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        got = 1'b0; n = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            if (bus.if_valid) got = 1'b1;
            else begin @(posedge clk); #1; n++; end
        end
        chk("drop_valid", 32'(got), 32'd1);
        chk("drop_cycles", 32'(n), 32'(LAT));
        chk("drop_d_valid", 32'(bus.d_valid), 32'd0);
        @(posedge clk); #1;

        // A request arriving during WAIT waits for DONE.
        bus.d_we = 1'b0; bus.d_size = 2'b10; bus.d_addr = 14'h0030;
        bus.if_addr = 14'h0040; bus.d_req = 1'b1;
        got = 1'b0; n = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            if (bus.ram_en) got = 1'b1;
            else begin @(posedge clk); #1; n++; end
        end
        chk("wait_d_grant", 32'(got), 32'd1);
        @(posedge clk); #1;
        bus.if_req = 1'b1;
        c = 0; dv = 0; gc = 0;
        while (gc == 0 && c < 20) begin
            @(negedge clk);
            c++;
            if (bus.d_valid) begin
                dv = c;
                chk("wait_d_rdata", bus.d_rdata, ref_word(14'h0030));
            end
            if (bus.ram_en) gc = c;
            else begin
                @(posedge clk); #1;
                if (dv != 0) bus.d_req = 1'b0;
            end
        end
        chk("wait_d_valid_at", 32'(dv), 32'(LAT + 1));
        chk("wait_if_grant_at", 32'(gc), 32'(LAT + 2));
        chk("wait_if_addr", 32'(bus.ram_addr), 32'h010);
        got = 1'b0; n = 0;
        while (!got && n < 20) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
            if (bus.if_valid) got = 1'b1;
        end
        chk("wait_if_valid", 32'(got), 32'd1);
        chk("wait_if_rdata", bus.if_rdata, ref_word(14'h0040));
        @(posedge clk); #1;
        bus.if_req = 1'b0;

        // Reset in WAIT: abandoned, no valid pulse.
        bus.if_addr = 14'h0010; bus.if_req = 1'b1;
        got = 1'b0; n = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            if (bus.ram_en) got = 1'b1;
            else begin @(posedge clk); #1; n++; end
        end
        chk("rstw_grant", 32'(got), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("rst_wait");
        nbad = 0;
        repeat (LAT + 2) begin
            @(negedge clk);
            if (bus.if_valid || bus.ram_en) nbad++;
        end
        chk("rst_no_pulse", 32'(nbad), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        acc(1'b0, 1'b0, 2'b00, 14'h0010, 32'h0, gw, gwe, ga, gwd);
        chk("rst_regrant_wait", 32'(gw), 32'd0);

        // Randomized single accesses against the byte model.
        for (int i = 0; i < 40; i++) begin
            isd = 1'($urandom_range(0, 1));
            we  = isd ? 1'($urandom_range(0, 1)) : 1'b0;
            sz  = 2'($urandom_range(0, 3));
            a   = 14'($urandom_range(0, 255));
            w   = $urandom;
            acc(isd, we, sz, a, w, gw, gwe, ga, gwd);
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
